// File: rtl/idct2_pkg.sv
// Shared state encoding, default widths and tap-count helper for the IDCT accumulate/round block.
package idct2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  localparam int PROD_W_DEF   = 32;
  localparam int ACC_W_DEF    = 40;
  localparam int OUT_W_DEF    = 16;
  localparam int MAX_TAPS_DEF = 32;

  // A zero tap count still means one product; oversize requests are capped.
  function automatic int clamp_taps(input int raw, input int max_taps);
    if (raw < 1) return 1;
    if (raw > max_taps) return max_taps;
    return raw;
  endfunction

endpackage

// File: rtl/idct2_round_clip.sv
// Combinational round-half-up, arithmetic right shift and output narrowing.
// Macro IDCT2_ACC_SAT_EN selects saturation; otherwise the result wraps and sat is 0.
module idct2_round_clip
  import idct2_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [4:0]       shift,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;

`ifdef IDCT2_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rnd  = '0;
    data = '0;
    sat  = 1'b0;
    if (shift != 5'd0) rnd = ACC_W'(1) << (shift - 5'd1);
    sum     = $signed(acc) + rnd;
    shifted = sum >>> shift;
`ifdef IDCT2_ACC_SAT_EN
    if (shifted > MAX_V) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = shifted[OUT_W-1:0];
    end
`else
    data = OUT_W'(shifted);
`endif
  end

endmodule

// File: rtl/idct2_acc_round.sv
// Accumulates a configurable number of signed products, then rounds/shifts/narrows one coefficient.
// Optional macro IDCT2_ACC_SAT_EN enables output saturation (see idct2_round_clip).
module idct2_acc_round
  import idct2_pkg::*;
#(
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int MAX_TAPS = MAX_TAPS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic [5:0]        cfg_taps,
  input  logic [4:0]        cfg_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int CNT_W = $clog2(MAX_TAPS + 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        taps_q, taps_d;
  logic [4:0]              shift_q, shift_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic [CNT_W-1:0]        taps_eff;
  logic signed [ACC_W-1:0] in_ext;
  logic                    in_xfer;
  logic                    out_xfer;
  logic [OUT_W-1:0]        rc_data;
  logic                    rc_sat;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign taps_eff = CNT_W'(clamp_taps(int'(cfg_taps), MAX_TAPS));
  // Accumulator headroom covers MAX_TAPS full-scale products without wrapping.
  assign in_ext   = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};

  idct2_round_clip #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_round_clip (
    .acc   (acc_q),
    .shift (shift_q),
    .data  (rc_data),
    .sat   (rc_sat)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    taps_d     = taps_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          acc_d   = in_ext;
          cnt_d   = CNT_W'(1);
          taps_d  = taps_eff;
          shift_d = cfg_shift;
          state_d = (taps_eff <= CNT_W'(1)) ? ST_ROUND : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_xfer) begin
          acc_d = acc_q + in_ext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == taps_q) state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_data_d = rc_data;
        out_sat_d  = rc_sat;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      taps_q     <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      taps_q     <= taps_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_idct2_acc_round.sv
// Scoreboard bench for idct2_acc_round: directed corner groups plus randomized groups against an arithmetic model.
module tb_idct2_acc_round;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [5:0]  cfg_taps = '0;
  logic [4:0]  cfg_shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  exp_t   sb_q[$];
  longint grp[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     rdy_force = 1'b0;
  bit     rdy_val   = 1'b1;

  idct2_acc_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_taps  (cfg_taps),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: exact integer sum, round half up, floor shift, then clip or wrap to 16 bits.
  function automatic exp_t model(input longint sum, input int shift);
    exp_t   e;
    longint r;
    longint v;
    logic [63:0] vb;
    r  = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    v  = (sum + r) >>> shift;
    vb = v;
`ifdef IDCT2_ACC_SAT_EN
    if (v > 32767) begin
      e.data = 32767; e.sat = 1'b1;
    end else if (v < -32768) begin
      e.data = -32768; e.sat = 1'b1;
    end else begin
      e.data = v; e.sat = 1'b0;
    end
`else
    e.data = longint'($signed(vb[15:0]));
    e.sat  = 1'b0;
`endif
    return e;
  endfunction

  function automatic int eff_taps(input int raw);
    if (raw < 1) return 1;
    if (raw > 32) return 32;
    return raw;
  endfunction

  // out_ready updates at #2 after each edge so stimulus at #1 can steer it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on every output transfer; while holding, data must already equal the expected value.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      check("in_ready_in_hold", longint'(in_ready), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_output", longint'(out_valid), 0);
      end else if (out_ready) begin
        check("out_data", longint'($signed(out_data)), sb_q[0].data);
        check("out_sat", longint'(out_sat), longint'(sb_q[0].sat));
        void'(sb_q.pop_front());
      end else begin
        check("hold_stable", longint'($signed(out_data)), sb_q[0].data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input longint d, input int ct, input int cs);
    int n;
    in_valid  = 1'b1;
    in_data   = d[31:0];
    cfg_taps  = ct[5:0];
    cfg_shift = cs[4:0];
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("accept_timeout", longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  // Sends grp; cfg is valid only on the first word, later words carry junk cfg to prove sampling.
  task automatic send_group(input int ct, input int cs, input bit push, input int max_bubble);
    longint sum;
    sum = 0;
    foreach (grp[i]) begin
      if (i > 0 && max_bubble > 0) repeat ($urandom_range(0, max_bubble)) step();
      if (i == 0) send_word(grp[i], ct, cs);
      else send_word(grp[i], int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
      sum += grp[i];
    end
    if (push) sb_q.push_back(model(sum, cs));
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check(name, longint'(out_valid), 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain", longint'(sb_q.size()), 0);
  endtask

  initial begin
    int t;
    int s;
    int mode;
    #12;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    reset = 1'b0;
    step();
    check("rst_in_ready", longint'(in_ready), 1);

    // Back-to-back sum and output latency.
    rdy_force = 1'b1; rdy_val = 1'b1;
    grp = '{10, 20, 30, 40};
    send_group(4, 0, 1'b1, 0);
    check("lat_round_no_valid", longint'(out_valid), 0);
    step();
    check("lat_hold_valid", longint'(out_valid), 1);
    wait_drain();

    // Rounding on both sides of the half point.
    grp = '{64, 0};
    send_group(2, 7, 1'b1, 0);
    grp = '{-64, 0};
    send_group(2, 7, 1'b1, 0);
    // Out-of-range single product: clip or wrap.
    grp = '{40000};
    send_group(1, 0, 1'b1, 0);
    // Full-scale negative with maximum taps.
    grp = {};
    repeat (32) grp.push_back(-64'sd2147483648);
    send_group(32, 31, 1'b1, 0);
    // Taps 0 acts as 1, taps 63 acts as 32.
    grp = '{1234};
    send_group(0, 2, 1'b1, 0);
    grp = {};
    repeat (32) grp.push_back(longint'($urandom_range(0, 1000)));
    send_group(63, 3, 1'b1, 0);
    wait_drain();

    // Backpressure: hold out_ready low 5 cycles in HOLD.
    rdy_val = 1'b0;
    grp = '{100, -300, 7};
    send_group(3, 1, 1'b1, 0);
    wait_out_valid("bp_valid_timeout");
    repeat (5) step();
    check("bp_still_valid", longint'(out_valid), 1);
    check("bp_in_ready_low", longint'(in_ready), 0);
    rdy_val = 1'b1;
    grp = '{-9, 3};
    send_group(2, 0, 1'b1, 0);
    wait_drain();

    // Reset mid-group discards the partial sum.
    rdy_force = 1'b0;
    grp = '{111, 222};
    send_group(4, 0, 1'b0, 0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    step();
    reset = 1'b0;
    check("midrst_in_ready", longint'(in_ready), 1);
    repeat (4) step();
    check("midrst_no_output", longint'(out_valid), 0);
    grp = '{5};
    send_group(1, 0, 1'b1, 0);
    wait_drain();

    // Reset in HOLD discards the pending coefficient.
    rdy_force = 1'b1; rdy_val = 1'b0;
    grp = '{77};
    send_group(1, 0, 1'b0, 0);
    wait_out_valid("holdrst_valid_timeout");
    reset = 1'b1;
    #1;
    check("holdrst_out_valid", longint'(out_valid), 0);
    check("holdrst_out_data", longint'(out_data), 0);
    step();
    reset = 1'b0;
    rdy_force = 1'b0;
    repeat (3) step();
    check("holdrst_no_output", longint'(out_valid), 0);

    // Randomized groups with bubbles and random backpressure.
    for (int g = 0; g < 60; g++) begin
      t    = int'($urandom_range(0, 40));
      s    = int'($urandom_range(0, 31));
      mode = int'($urandom_range(0, 2));
      grp  = {};
      for (int k = 0; k < eff_taps(t); k++) begin
        if (mode == 0) grp.push_back(longint'($signed($urandom())));
        else if (mode == 1) grp.push_back(longint'($urandom_range(0, 8000)) - 4000);
        else grp.push_back(longint'($urandom_range(0, 200000)) - 100000);
      end
      if (mode != 0) s = int'($urandom_range(0, 6));
      send_group(t, s, 1'b1, 2);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idct2_acc_round.md
IDCT2_ACC_ROUND -- requirements
Module: idct2_acc_round

Interface
REQ-001 The block SHALL have parameter PROD_W, default 32, meaning width of incoming signed product.
REQ-002 The block SHALL have parameter ACC_W, default 40, meaning signed accumulator width.
REQ-003 The block SHALL have parameter OUT_W, default 16, meaning signed output coefficient width.
REQ-004 The block SHALL have parameter MAX_TAPS, default 32, meaning maximum products summed per output.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a product is presented.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the product this cycle.
REQ-009 The block SHALL have port in_data, input, PROD_W bits: signed product from the upstream multiplier.
REQ-010 The block SHALL have port cfg_taps, input, 6 bits: products per output, sampled on the first accept of a group.
REQ-011 The block SHALL have port cfg_shift, input, 5 bits: right-shift amount, sampled with cfg_taps.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds a finished coefficient.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 The block SHALL have port out_data, output, OUT_W bits: signed rounded, shifted coefficient.
REQ-015 The block SHALL have port out_sat, output, 1 bit: out_data was clipped.

Function
REQ-016 A transfer SHALL occur on a rising edge with in_valid and in_ready both high; out transfer likewise with out_valid and out_ready.
REQ-017 The FSM SHALL have states IDLE, ACCUM, ROUND, HOLD.
REQ-018 IDLE on transfer: acc = sign-extended in_data, tap count = 1, cfg latched; go ACCUM, or ROUND if latched taps <= 1.
REQ-019 ACCUM on transfer: acc += sign-extended in_data, count += 1; go ROUND when count reaches latched taps.
REQ-020 cfg_taps of 0 SHALL be treated as 1; values above MAX_TAPS SHALL be treated as MAX_TAPS.
REQ-021 ROUND SHALL compute (acc + (shift ? 1<<(shift-1) : 0)) >>> shift in ACC_W bits, register it into out_data, and go HOLD.
REQ-022 out_valid SHALL be high exactly in HOLD; the first out_valid edge is the second rising edge after the final input transfer.
REQ-023 HOLD SHALL keep out_data and out_sat stable until out transfer, then go IDLE.
REQ-024 in_ready SHALL be high in IDLE and ACCUM only, independent of in_valid.
REQ-025 ACCUM with in_valid low SHALL hold acc and count unchanged (bubbles tolerated indefinitely).
REQ-026 A group with MAX_TAPS inputs of full-scale PROD_W magnitude SHALL NOT overflow ACC_W.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, acc 0, count 0, latched cfg 0, out_data 0, out_sat 0, out_valid 0, in_ready 1 after release.
REQ-028 Reset mid-group or in HOLD SHALL discard partial sums and pending output without emitting them.

Configuration
REQ-029 Macro IDCT2_ACC_SAT_EN defined: the shifted result SHALL be clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and out_sat set when clipping occurs.
REQ-030 Macro IDCT2_ACC_SAT_EN undefined: the shifted result SHALL be truncated to its low OUT_W bits (two's-complement wrap) and out_sat tied 0.

Structure
REQ-031 Package idct2_pkg SHALL hold the state enum, default widths, and the MAX_TAPS constant.
REQ-032 Rounding, shifting and clipping SHALL live in one combinational sub-module idct2_round_clip.

Verification
REQ-033 Taps 4, shift 0, inputs 10,20,30,40 back-to-back -> out_data 100, out_valid 2 cycles after last accept.
REQ-034 Taps 2, shift 7, inputs 64,0 -> out_data 1 (rounding); inputs -64,0 -> out_data 0.
REQ-035 Taps 1, shift 0, input 40000 -> with SAT_EN out_data 32767, out_sat 1; without, out_data -25536, out_sat 0.
REQ-036 Taps 3, out_ready held low 5 cycles -> out_data stable, in_ready 0 throughout, next group accepted after handshake.
REQ-037 Reset asserted after 2 of 4 inputs -> no output; fresh group of taps 1, input 5 -> out_data 5.
REQ-038 Taps 32, all inputs -2^31, shift 31 -> out_data -32 with no accumulator wrap.
